// File: rtl/clock_pkg.sv
// Shared types, moduli and BCD helpers for the clock datapath counters.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MOD    = 60;
  localparam int MIN_MOD    = 60;
  localparam int HOUR24_MOD = 24;
  localparam int HOUR12_MOD = 12;

  // What a counter does at the coming edge, decided before the digit update.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_REJECT,
    OP_STEP
  } op_e;

  function automatic logic [7:0] to_bcd(int v);
    bcd_t h;
    bcd_t l;
    h = bcd_t'(v / 10);
    l = bcd_t'(v % 10);
    return {h, l};
  endfunction

  function automatic logic bcd_valid(bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single BCD digit increment/decrement with a wrap limit.
module bcd_digit_step
  import clock_pkg::*;
(
  input  bcd_t digit,
  input  logic up,
  input  bcd_t limit,
  output bcd_t next,
  output logic wrap
);

  always_comb begin
    next = digit;
    wrap = 1'b0;
    if (up) begin
      if (digit >= limit) begin
        next = '0;
        wrap = 1'b1;
      end else begin
        next = digit + 4'd1;
      end
    end else begin
      if (digit == '0) begin
        next = limit;
        wrap = 1'b1;
      end else begin
        next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD up/down counter with preset and carry/borrow pulse.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD  = 24,
  parameter int INIT = 0
)
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] ld_h,
  input  logic [3:0] ld_l,
  output logic [3:0] cnt_h,
  output logic [3:0] cnt_l,
  output logic       carry,
  output logic       ld_err
);

  if (MOD < 2 || MOD > 99 || INIT < 0 || INIT >= MOD) begin : g_param_check
    $fatal(1, "bcd_mod_counter: illegal MOD=%0d INIT=%0d", MOD, INIT);
  end

  localparam logic [7:0] INIT_BCD = to_bcd(INIT);
  localparam logic [7:0] TOP_BCD  = to_bcd(MOD - 1);
  localparam bcd_t       TOP_H    = TOP_BCD[7:4];
  localparam bcd_t       TOP_L    = TOP_BCD[3:0];

  bcd_t l_next;
  bcd_t h_next;
  logic l_wrap;
  logic h_wrap;
  logic terminal;
  logic preset_ok;
  op_e  op;

  bcd_t d_h;
  bcd_t d_l;
  logic d_carry;
  logic d_err;

  bcd_digit_step u_units (
    .digit (cnt_l),
    .up    (up),
    .limit (4'd9),
    .next  (l_next),
    .wrap  (l_wrap)
  );

  bcd_digit_step u_tens (
    .digit (cnt_h),
    .up    (up),
    .limit (TOP_H),
    .next  (h_next),
    .wrap  (h_wrap)
  );

  // Tens wrap flags "tens at its extreme"; the modulus wrap also needs the units digit.
  always_comb begin
    terminal = 1'b0;
    if (up) begin
      terminal = h_wrap && (cnt_l == TOP_L);
    end else begin
      terminal = h_wrap && l_wrap;
    end
  end

  // Digit-wise compare against MOD-1 keeps the check in 4-bit arithmetic.
  always_comb begin
    preset_ok = bcd_valid(ld_h) && bcd_valid(ld_l) &&
                ((ld_h < TOP_H) || ((ld_h == TOP_H) && (ld_l <= TOP_L)));
  end

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = preset_ok ? OP_LOAD : OP_REJECT;
    end else if (en) begin
      op = OP_STEP;
    end
  end

  always_comb begin
    d_h     = cnt_h;
    d_l     = cnt_l;
    d_carry = 1'b0;
    d_err   = 1'b0;
    unique case (op)
      OP_LOAD: begin
        d_h = ld_h;
        d_l = ld_l;
      end
      OP_REJECT: begin
        d_err = 1'b1;
      end
      OP_STEP: begin
        if (terminal) begin
          {d_h, d_l} = up ? 8'h00 : TOP_BCD;
          d_carry    = 1'b1;
        end else begin
          d_l = l_next;
          d_h = l_wrap ? h_next : cnt_h;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_h  <= INIT_BCD[7:4];
      cnt_l  <= INIT_BCD[3:0];
      carry  <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      cnt_h  <= d_h;
      cnt_l  <= d_l;
      carry  <= d_carry;
      ld_err <= d_err;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: several parameterisations plus a sec/min/hour chain.
module tb_bcd_mod_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr2;

  // Index 0: MOD24/INIT0, 1: MOD60, 2: MOD24/INIT23, 3: MOD12, 4..6: sec/min/hour chain
  logic       en   [5];
  logic       up   [5];
  logic       load [5];
  logic [3:0] ldh  [5];
  logic [3:0] ldl  [5];
  logic [3:0] qh   [7];
  logic [3:0] ql   [7];
  logic       cy   [7];
  logic       er   [7];

  bcd_mod_counter #(.MOD(24), .INIT(0)) u0 (
    .clk(clk), .clr(rst), .en(en[0]), .up(up[0]), .load(load[0]), .ld_h(ldh[0]), .ld_l(ldl[0]),
    .cnt_h(qh[0]), .cnt_l(ql[0]), .carry(cy[0]), .ld_err(er[0]));
  bcd_mod_counter #(.MOD(60), .INIT(0)) u1 (
    .clk(clk), .clr(rst), .en(en[1]), .up(up[1]), .load(load[1]), .ld_h(ldh[1]), .ld_l(ldl[1]),
    .cnt_h(qh[1]), .cnt_l(ql[1]), .carry(cy[1]), .ld_err(er[1]));
  bcd_mod_counter #(.MOD(24), .INIT(23)) u2 (
    .clk(clk), .clr(clr2), .en(en[2]), .up(up[2]), .load(load[2]), .ld_h(ldh[2]), .ld_l(ldl[2]),
    .cnt_h(qh[2]), .cnt_l(ql[2]), .carry(cy[2]), .ld_err(er[2]));
  bcd_mod_counter #(.MOD(HOUR12_MOD), .INIT(0)) u3 (
    .clk(clk), .clr(rst), .en(en[3]), .up(up[3]), .load(load[3]), .ld_h(ldh[3]), .ld_l(ldl[3]),
    .cnt_h(qh[3]), .cnt_l(ql[3]), .carry(cy[3]), .ld_err(er[3]));
  bcd_mod_counter #(.MOD(SEC_MOD), .INIT(59)) u_sec (
    .clk(clk), .clr(rst), .en(en[4]), .up(up[4]), .load(load[4]), .ld_h(ldh[4]), .ld_l(ldl[4]),
    .cnt_h(qh[4]), .cnt_l(ql[4]), .carry(cy[4]), .ld_err(er[4]));
  bcd_mod_counter #(.MOD(MIN_MOD), .INIT(59)) u_min (
    .clk(clk), .clr(rst), .en(cy[4]), .up(up[4]), .load(1'b0), .ld_h(4'h0), .ld_l(4'h0),
    .cnt_h(qh[5]), .cnt_l(ql[5]), .carry(cy[5]), .ld_err(er[5]));
  bcd_mod_counter #(.MOD(HOUR24_MOD), .INIT(23)) u_hr (
    .clk(clk), .clr(rst), .en(cy[5]), .up(up[4]), .load(1'b0), .ld_h(4'h0), .ld_l(4'h0),
    .cnt_h(qh[6]), .cnt_l(ql[6]), .carry(cy[6]), .ld_err(er[6]));

  typedef struct {
    int         id;
    logic [7:0] v;
    logic       c;
    logic       e;
    int         tag;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event async_ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp(int id, logic [7:0] v, logic c, logic e, string nm, int tag);
    exp_t x;
    x.id = id; x.v = v; x.c = c; x.e = e; x.nm = nm; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic drive(int id, logic e, logic u, logic l, logic [3:0] h, logic [3:0] lo);
    en[id] = e; up[id] = u; load[id] = l; ldh[id] = h; ldl[id] = lo;
  endtask

  // Apply inputs for one edge, expect the given registered result after it.
  task automatic op(int id, logic e, logic u, logic l, logic [3:0] h, logic [3:0] lo,
                    logic [7:0] v, logic c, logic er_exp, string nm);
    drive(id, e, u, l, h, lo);
    exp(id, v, c, er_exp, nm, cyc + 1);
    @(negedge clk);
    drive(id, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  function automatic logic [7:0] bcd8(int v);
    logic [3:0] h;
    logic [3:0] l;
    h = 4'(v / 10);
    l = 4'(v % 10);
    return {h, l};
  endfunction

  // Monitor: compares every due expectation at the falling edge or after an async clear.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk or async_ev);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        x = q.pop_front();
        n_cmp++;
        if ({qh[x.id], ql[x.id]} !== x.v || cy[x.id] !== x.c || er[x.id] !== x.e) begin
          n_bad++;
          $display("FAIL %s: got %h%h carry=%b ld_err=%b, want %h carry=%b ld_err=%b",
                   x.nm, qh[x.id], ql[x.id], cy[x.id], er[x.id], x.v, x.c, x.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    clr2 = 1'b1;
    for (int i = 0; i < 5; i++) drive(i, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    exp(0, 8'h00, 1'b0, 1'b0, "rst_u0", 0);
    exp(1, 8'h00, 1'b0, 1'b0, "rst_u1", 0);
    exp(2, 8'h23, 1'b0, 1'b0, "rst_u2_init23", 0);
    exp(3, 8'h00, 1'b0, 1'b0, "rst_u3", 0);
    exp(4, 8'h59, 1'b0, 1'b0, "rst_sec", 0);
    exp(5, 8'h59, 1'b0, 1'b0, "rst_min", 0);
    exp(6, 8'h23, 1'b0, 1'b0, "rst_hr", 0);
    @(negedge clk);
    rst  = 1'b0;
    clr2 = 1'b0;

    // MOD24 full up cycle, then down across the borrow and a tens boundary
    for (int i = 1; i <= 24; i++)
      op(0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, bcd8(i % 24), (i == 24), 1'b0, "u0_up_seq");
    for (int i = 1; i <= 5; i++)
      op(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, bcd8(24 - i), (i == 1), 1'b0, "u0_down_seq");
    op(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h19, 1'b0, 1'b0, "u0_hold");

    // MOD60 preset at the extremes and wraps in both directions
    op(1, 1'b0, 1'b0, 1'b1, 4'h5, 4'h9, 8'h59, 1'b0, 1'b0, "u1_load59");
    op(1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, "u1_up_wrap");
    op(1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, "u1_load00");
    op(1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h59, 1'b1, 1'b0, "u1_down_borrow");
    op(1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h59, 1'b0, 1'b0, "u1_hold");
    op(1, 1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 8'h59, 1'b0, 1'b1, "u1_load60_rej");
    op(1, 1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 8'h59, 1'b0, 1'b1, "u1_load99_rej");
    op(1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h59, 1'b0, 1'b0, "u1_err_drops");

    // MOD12: load beats enable; out-of-range preset
    op(3, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 8'h11, 1'b0, 1'b0, "u3_load11");
    op(3, 1'b1, 1'b1, 1'b1, 4'h0, 4'h5, 8'h05, 1'b0, 1'b0, "u3_load_wins");
    op(3, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 8'h11, 1'b0, 1'b0, "u3_reload11");
    op(3, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, "u3_up_wrap");
    op(3, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 8'h01, 1'b0, 1'b0, "u3_carry_drops");
    op(3, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 8'h01, 1'b0, 1'b1, "u3_load12_rej");
    op(3, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 8'h01, 1'b0, 1'b1, "u3_bad_load_no_step");

    // MOD24/INIT23: rejected presets, async clear mid-count and with carry pending
    op(2, 1'b0, 1'b0, 1'b1, 4'h2, 4'h4, 8'h23, 1'b0, 1'b1, "u2_load24_rej");
    op(2, 1'b0, 1'b0, 1'b1, 4'h0, 4'hA, 8'h23, 1'b0, 1'b1, "u2_load0A_rej");
    op(2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h23, 1'b0, 1'b0, "u2_hold");
    op(2, 1'b0, 1'b0, 1'b1, 4'h1, 4'h5, 8'h15, 1'b0, 1'b0, "u2_load15");
    #2 clr2 = 1'b1;
    #1 exp(2, 8'h23, 1'b0, 1'b0, "u2_clr_async", cyc);
    -> async_ev;
    drive(2, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    exp(2, 8'h23, 1'b0, 1'b0, "u2_clr_held", cyc + 1);
    @(negedge clk);
    clr2 = 1'b0;
    op(2, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, "u2_wrap_after_clr");
    #2 clr2 = 1'b1;
    #1 exp(2, 8'h23, 1'b0, 1'b0, "u2_clr_kills_carry", cyc);
    -> async_ev;
    @(negedge clk);
    clr2 = 1'b0;
    op(2, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, "u2_wrap_again");
    op(2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, "u2_carry_drops");

    // Chain 23:59:59 with one seconds step; each registered carry ripples one cycle later
    drive(4, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    exp(4, 8'h00, 1'b1, 1'b0, "chain1_sec", cyc + 1);
    exp(5, 8'h59, 1'b0, 1'b0, "chain1_min", cyc + 1);
    exp(6, 8'h23, 1'b0, 1'b0, "chain1_hr", cyc + 1);
    @(negedge clk);
    en[4] = 1'b0;
    exp(4, 8'h00, 1'b0, 1'b0, "chain2_sec", cyc + 1);
    exp(5, 8'h00, 1'b1, 1'b0, "chain2_min", cyc + 1);
    exp(6, 8'h23, 1'b0, 1'b0, "chain2_hr", cyc + 1);
    @(negedge clk);
    exp(4, 8'h00, 1'b0, 1'b0, "chain3_sec", cyc + 1);
    exp(5, 8'h00, 1'b0, 1'b0, "chain3_min", cyc + 1);
    exp(6, 8'h00, 1'b1, 1'b0, "chain3_hr", cyc + 1);
    @(negedge clk);
    exp(6, 8'h00, 1'b0, 1'b0, "chain4_hr", cyc + 1);
    @(negedge clk);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
